dct_zigzag_buf: RTL and testbench
=================================

// Module: dct_zigzag_buf
// PURPOSE
//  Block reorder stage directly downstream of the 2-D DCT wrapper.
//  - Collects the 8 row beats of each 8x8 coefficient block (8 coefficients/beat) into a ping-pong register buffer.
//  - Re-emits each block as 8 beats in JPEG zigzag order, feeding the quantiser/entropy coder.
//  - Streaming, no backpressure, same valid/sob/eob/sof framing on both sides.
// PARAMETERS
//  W   16  coefficient width (bits); data passed through unmodified (sign kept)
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input row beat valid
//  in_data    in   [7:0][W] row r of block; in_data[c] = coefficient (r,c), raster idx 8r+c
//  in_sob     in   1        first row of block (row 0)
//  in_eob     in   1        last row of block (row 7)
//  in_sof     in   1        block is first of frame (meaningful with in_sob)
//  out_valid  out  1        output beat valid
//  out_data   out  [7:0][W] beat k: out_data[j] = coefficient at zigzag position 8k+j
//  out_sob    out  1        beat 0 of block
//  out_eob    out  1        beat 7 of block
//  out_sof    out  1        beat 0 of a block captured with in_sof on its row 0
//  err        out  1        1-cycle pulse: framing error or overflow (see below)
// BEHAVIOUR
//  Reset: all outputs 0; row counter 0; write bank 0; both bank-full flags 0; read FSM IDLE.
//  Reset mid-operation discards partial and stored blocks; no output until a new full block arrives.
//  Write side (only when in_valid):
//  - Row counter selects the row; in_sob forces row 0 and discards any partial block.
//  - Row 7 written -> bank marked full, sof flag stored, write bank toggles, counter -> 0.
//  - in_eob on row!=7, or missing on row 7 -> err pulse; block still completes on the 8th row.
//  - in_sob on a row other than 0 -> err pulse.
//  - Block completes into a bank still full (unread) -> err pulse; data overwritten; that bank's
//    read restarts at beat 0 if it is the bank currently being read.
//  Read FSM:
//  - IDLE: a bank full -> READ(bank, beat 0); bank 0 wins if both full.
//  - READ: one beat per cycle, beat 0..7.
//  - After beat 7: bank-full cleared; if other bank full -> READ(other, 0) with no gap; else IDLE.
//  - Bank-full set and cleared in the same cycle (simultaneous events): set wins for the
//    other bank, clear applies to the read bank.
//  Outputs are registered. Row 7 presented in cycle n -> beat 0 in cycle n+2, beats in n+2..n+9.
//  out_valid=0 between blocks; out_data holds last value when invalid.
//  Throughput: continuous input (1 block / 8 cycles) -> continuous output, no err.
//  Zigzag: out beat k, lane j = buffer[ZZ[8k+j]], ZZ = standard JPEG zigzag->raster table.
// STRUCTURE
//  jpeg_pkg: localparam logic [5:0] ZZ_IDX[64] (zigzag->raster), BLK_ROWS=8, typedef coef_row_t.
//  Read FSM enum in jpeg_pkg.
//  Single module: 2x64xW register file, write counter, read FSM, output registers.
//  No sub-module; zigzag mux is a generate loop over ZZ_IDX.
// TESTING
//  1. Block with raster value = index, rows 0..7 consecutive -> beat0 {0,1,8,16,9,2,3,10},
//     beat6 {58,59,52,45,38,31,39,46}, beat7 {53,60,61,54,47,55,62,63};
//     sob on beat0, eob on beat7, first beat 2 cycles after row 7.
//  2. 4 back-to-back blocks, in_sof on block 0 only -> 32 consecutive valid out beats;
//     out_sof only on beat0 of block 0; err never set.
//  3. Rows with in_valid gaps (random 0-3 idle cycles) -> identical out data vs. reference model;
//     err=0.
//  4. in_sob at row 4 then 8 good rows -> err pulse once; only the second block output.
//  5. in_eob on row 5 -> err pulse; block still emitted after row 7.
//  6. Reset asserted while bank 1 reading beat 3 -> out_valid=0 immediately (async);
//     after release no output until next complete block.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG block reorder path.
// ZZ_IDX maps a zigzag position to the raster index of its coefficient.
package jpeg_pkg;

  localparam int COEF_W   = 16;
  localparam int BLK_ROWS = 8;

  typedef logic [7:0][COEF_W-1:0] coef_row_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  localparam logic [5:0] ZZ_IDX [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dct_zigzag_buf.sv
// Ping-pong 8x8 block buffer: collects DCT rows in raster order and
// re-emits each block as 8 beats of 8 coefficients in JPEG zigzag order.
module dct_zigzag_buf
  import jpeg_pkg::*;
#(
  parameter int W = COEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0][W-1:0] in_data,
  input  logic              in_sob,
  input  logic              in_eob,
  input  logic              in_sof,
  output logic              out_valid,
  output logic [7:0][W-1:0] out_data,
  output logic              out_sob,
  output logic              out_eob,
  output logic              out_sof,
  output logic              err
);

  logic [7:0][W-1:0] mem [2][BLK_ROWS];

  logic [2:0]        wr_row;
  logic              wr_bank;
  logic [1:0]        full;
  logic [1:0]        sof_flag;
  logic              sof_pend;

  rd_state_t         rd_state;
  logic              rd_bank;
  logic [2:0]        rd_beat;

  logic [2:0]        row_sel;
  logic              wr_done;
  logic              rd_last;
  logic              restart;
  logic              other_full;
  logic              overflow;
  logic              frame_err;
  logic [1:0]        full_nxt;
  logic              emit_bank;
  logic [2:0]        emit_beat;

  logic [W-1:0]      zz [64];
  logic [7:0][W-1:0] beat_data;

  // Write decode, bank-full bookkeeping and choice of the beat to emit
  always_comb begin
    row_sel    = in_sob ? 3'd0 : wr_row;
    wr_done    = in_valid && (row_sel == 3'd7);
    rd_last    = (rd_state == RD_READ) && (rd_beat == 3'd7);
    overflow   = wr_done && full[wr_bank] && !(rd_last && (rd_bank == wr_bank));
    frame_err  = in_valid && ((in_sob && (wr_row != 3'd0)) || (in_eob != (row_sel == 3'd7)));
    restart    = wr_done && (rd_state == RD_READ) && (wr_bank == rd_bank) && !rd_last;
    // A block landing in the other bank this very cycle lets the read chain on without a gap
    other_full = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));
    full_nxt   = full;
    for (int b = 0; b < 2; b++) begin
      if (rd_last && (rd_bank == 1'(b))) begin
        full_nxt[b] = 1'b0;
      end else if (wr_done && (wr_bank == 1'(b))) begin
        full_nxt[b] = 1'b1;
      end else begin
        full_nxt[b] = full[b];
      end
    end
    if (rd_state == RD_READ) begin
      emit_bank = rd_bank;
      emit_beat = rd_beat;
    end else begin
      emit_bank = ~full[0];
      emit_beat = 3'd0;
    end
  end

  for (genvar p = 0; p < 64; p++) begin : g_zz
    assign zz[p] = mem[emit_bank][ZZ_IDX[p][5:3]][ZZ_IDX[p][2:0]];
  end

  for (genvar j = 0; j < 8; j++) begin : g_lane
    assign beat_data[j] = zz[{emit_beat, 3'(j)}];
  end

  // Row storage; contents are only meaningful once the bank-full flag says so
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_bank][row_sel] <= in_data;
    end
  end

  // Write counter, bank flags and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row   <= 3'd0;
      wr_bank  <= 1'b0;
      full     <= 2'b00;
      sof_flag <= 2'b00;
      sof_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      full <= full_nxt;
      err  <= frame_err || overflow;
      if (in_valid) begin
        wr_row <= row_sel + 3'd1;
        if (row_sel == 3'd0) begin
          sof_pend <= in_sof && in_sob;
        end
        if (wr_done) begin
          wr_bank           <= ~wr_bank;
          sof_flag[wr_bank] <= sof_pend;
        end
      end
    end
  end

  // Read FSM with registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      rd_bank   <= 1'b0;
      rd_beat   <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (full != 2'b00) begin
            rd_state  <= RD_READ;
            rd_bank   <= emit_bank;
            rd_beat   <= 3'd1;
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_sob   <= 1'b1;
            out_eob   <= 1'b0;
            out_sof   <= sof_flag[emit_bank];
          end else begin
            out_valid <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
          end
        end
        RD_READ: begin
          out_valid <= 1'b1;
          out_data  <= beat_data;
          out_sob   <= (rd_beat == 3'd0);
          out_eob   <= rd_last;
          out_sof   <= (rd_beat == 3'd0) && sof_flag[rd_bank];
          if (restart) begin
            rd_beat <= 3'd0;
          end else if (rd_last) begin
            rd_beat <= 3'd0;
            if (other_full) begin
              rd_bank <= ~rd_bank;
            end else begin
              rd_state <= RD_IDLE;
            end
          end else begin
            rd_beat <= rd_beat + 3'd1;
          end
        end
        default: begin
          rd_state  <= RD_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_zigzag_buf.sv
// Directed bench for dct_zigzag_buf: table-checked first block, then
// scoreboarded streams covering back-to-back, gaps, framing errors and reset.
module tb_dct_zigzag_buf;
  import jpeg_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
  coef_row_t in_data = '0;
  logic      out_valid, out_sob, out_eob, out_sof, err;
  coef_row_t out_data;

  dct_zigzag_buf #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
    .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob),
    .out_eob(out_eob), .out_sof(out_sof), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    coef_row_t data;
    logic      sob, eob, sof;
    int        cyc;
  } beat_t;

  typedef struct {
    int        beat;
    coef_row_t exp;
    logic      sob, eob;
  } vec_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  int          cyc = 0;
  int          err_cnt = 0;
  int          n_cmp = 0, n_bad = 0;
  int          zz_ord[64];
  logic [15:0] cur_blk[64];
  int          last_row7_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) got_q.push_back('{data: out_data, sob: out_sob, eob: out_eob, sof: out_sof, cyc: cyc});
      if (err) err_cnt = err_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Zigzag order derived independently by walking the anti-diagonals
  task automatic build_zz();
    int i = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ord[i] = 8 * r + (s - r); i++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ord[i] = 8 * r + (s - r); i++; end
      end
    end
  endtask

  task automatic fill_blk(input bit raster);
    for (int i = 0; i < 64; i++) cur_blk[i] = raster ? 16'(i) : 16'($urandom);
  endtask

  task automatic drive_row(input int r, input logic sob, input logic eob, input logic sof);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sob = sob; in_eob = eob; in_sof = sof;
    for (int c = 0; c < 8; c++) in_data[c] = cur_blk[8 * r + c];
    if (r == 7) last_row7_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic expect_block(input logic sof);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) b.data[j] = cur_blk[zz_ord[8 * k + j]];
      b.sob = (k == 0); b.eob = (k == 7); b.sof = sof && (k == 0); b.cyc = 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_block(input logic sof, input int max_gap, input int eob_row);
    for (int r = 0; r < 8; r++) begin
      drive_row(r, r == 0, (r == 7) || (r == eob_row), sof && (r == 0));
      if (max_gap > 0 && r < 7) idle($urandom_range(max_gap, 0));
    end
    expect_block(sof);
  endtask

  task automatic drain();
    idle(1);
    for (int k = 0; k < 80 && got_q.size() < exp_q.size(); k++) begin
      @(negedge clk); #1;
    end
    idle(4);
  endtask

  task automatic compare_stream(input string name);
    int n;
    drain();
    check({name, "_count"}, 160'(got_q.size()), 160'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", name, i),
            {29'd0, got_q[i].sof, got_q[i].eob, got_q[i].sob, got_q[i].data},
            {29'd0, exp_q[i].sof, exp_q[i].eob, exp_q[i].sob, exp_q[i].data});
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    vec_t tv[3];
    int   r7, gaps, sofs;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[3];
    int   r7, gaps, sofs;
    build_zz();

    tv[0] = '{beat: 0, exp: {16'd10, 16'd3, 16'd2, 16'd9, 16'd16, 16'd8, 16'd1, 16'd0}, sob: 1'b1, eob: 1'b0};
    tv[1] = '{beat: 6, exp: {16'd46, 16'd39, 16'd31, 16'd38, 16'd45, 16'd52, 16'd59, 16'd58}, sob: 1'b0, eob: 1'b0};
    tv[2] = '{beat: 7, exp: {16'd63, 16'd62, 16'd55, 16'd47, 16'd54, 16'd61, 16'd60, 16'd53}, sob: 1'b0, eob: 1'b1};

    // Reset state
    #12;
    check("rst_flags", {155'd0, out_valid, out_sob, out_eob, out_sof, err}, 160'd0);
    check("rst_data", 160'(out_data), 160'd0);
    #10 rst_n = 1'b1;
    idle(2);

    // 1: raster-index block, table-checked beats and latency
    fill_blk(1'b1);
    send_block(1'b0, 0, -1);
    r7 = last_row7_cyc;
    drain();
    check("t1_count", 160'(got_q.size()), 160'd8);
    for (int i = 0; i < 3; i++) begin
      if (tv[i].beat < got_q.size())
        check($sformatf("t1_tab%0d", tv[i].beat),
              {30'd0, got_q[tv[i].beat].sob, got_q[tv[i].beat].eob, got_q[tv[i].beat].data},
              {30'd0, tv[i].sob, tv[i].eob, tv[i].exp});
      else
        check($sformatf("t1_tab%0d_missing", tv[i].beat), 160'd0, 160'd1);
    end
    if (got_q.size() > 0) check("t1_latency", 160'(got_q[0].cyc), 160'(r7 + 2));
    compare_stream("t1");

    // 2: four back-to-back blocks, sof on the first only
    err_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      fill_blk(1'b0);
      send_block(b == 0, 0, -1);
    end
    drain();
    gaps = 0; sofs = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i].cyc != got_q[0].cyc + i) gaps++;
      if (got_q[i].sof) sofs++;
    end
    check("t2_contiguous", 160'(gaps), 160'd0);
    check("t2_sof_count", 160'(sofs), 160'd1);
    compare_stream("t2");
    check("t2_err", 160'(err_cnt), 160'd0);

    // 3: random idle gaps between rows
    err_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      fill_blk(1'b0);
      send_block(1'b0, 3, -1);
    end
    compare_stream("t3");
    check("t3_err", 160'(err_cnt), 160'd0);

    // 4: partial block abandoned by an early sob
    err_cnt = 0;
    fill_blk(1'b0);
    for (int r = 0; r < 4; r++) drive_row(r, r == 0, 1'b0, 1'b0);
    fill_blk(1'b0);
    send_block(1'b0, 0, -1);
    compare_stream("t4");
    check("t4_err", 160'(err_cnt), 160'd1);

    // 5: stray eob on row 5
    err_cnt = 0;
    fill_blk(1'b0);
    send_block(1'b0, 1, 5);
    compare_stream("t5");
    check("t5_err", 160'(err_cnt), 160'd1);

    // 6: async reset while bank 1 is on beat 3
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    fill_blk(1'b0);
    send_block(1'b1, 0, -1);
    fill_blk(1'b0);
    send_block(1'b0, 0, -1);
    idle(1);
    for (int k = 0; k < 60 && got_q.size() < 12; k++) begin
      @(negedge clk); #1;
    end
    check("t6_reach_beat3", 160'(got_q.size() >= 12), 160'd1);
    if (got_q.size() >= 12) check("t6_beat3_data", 160'(got_q[11].data), 160'(exp_q[11].data));
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {158'd0, out_valid, out_sob}, 160'd0);
    idle(2);
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    idle(30);
    check("t6_quiet", 160'(got_q.size()), 160'd0);
    fill_blk(1'b0);
    send_block(1'b0, 0, -1);
    compare_stream("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
